// File: rtl/apu_wb_queue.sv
// apu_wb_queue: in-order APU result write-back queue with a register busy scoreboard.
// Define APU_WB_DROP_X0_EN to accept but discard results destined for register 0.
module apu_wb_queue #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5,
    parameter int num_regs      = 32,
    parameter int depth         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [reg_sel_width-1:0] in_sel,
    input  logic [data_width-1:0]    in_data,
    output logic                     apu_wr_req,
    input  logic                     apu_ack,
    output logic [reg_sel_width-1:0] apu_wr_sel,
    output logic [data_width-1:0]    apu_wr_data,
    input  logic                     reserve_valid,
    input  logic [reg_sel_width-1:0] reserve_sel,
    input  logic [reg_sel_width-1:0] rs1_sel,
    input  logic [reg_sel_width-1:0] rs2_sel,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [$clog2(depth):0]   count
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [data_width-1:0]    mem_data [depth];
    logic [reg_sel_width-1:0] mem_sel  [depth];

    logic [aw-1:0] rd_ptr;
    logic [aw-1:0] wr_ptr;
    logic [aw-1:0] rd_ptr_nxt;

    logic push;
    logic enq;
    logic pop;

    logic                     req_nxt;
    logic [reg_sel_width-1:0] sel_nxt;
    logic [data_width-1:0]    data_nxt;

    logic [num_regs-1:0] busy;
    logic [num_regs-1:0] busy_set;
    logic [num_regs-1:0] busy_clr;

    assign in_ready   = (count != cw'(depth));
    assign pop        = (state == WAIT) && apu_ack;
    assign rd_ptr_nxt = rd_ptr + aw'(1);

    // A retiring write frees a slot, so a full queue still takes a result.
    assign push = in_valid && (in_ready || pop);

`ifdef APU_WB_DROP_X0_EN
    assign enq = push && (in_sel != '0);
`else
    assign enq = push;
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_sel[wr_ptr]  <= in_sel;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (enq && !pop) begin
                count <= count + cw'(1);
            end else if (!enq && pop) begin
                count <= count - cw'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        sel_nxt   = apu_wr_sel;
        data_nxt  = apu_wr_data;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    sel_nxt   = mem_sel[rd_ptr];
                    data_nxt  = mem_data[rd_ptr];
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (apu_ack) begin
                    // Chain straight to the next entry already held in the queue.
                    if (count > cw'(1)) begin
                        state_nxt = REQ;
                        req_nxt   = 1'b1;
                        sel_nxt   = mem_sel[rd_ptr_nxt];
                        data_nxt  = mem_data[rd_ptr_nxt];
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            apu_wr_req  <= 1'b0;
            apu_wr_sel  <= '0;
            apu_wr_data <= '0;
        end else begin
            state       <= state_nxt;
            apu_wr_req  <= req_nxt;
            apu_wr_sel  <= sel_nxt;
            apu_wr_data <= data_nxt;
        end
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (pop) begin
            busy_clr[apu_wr_sel] = 1'b1;
        end
        if (reserve_valid && (reserve_sel != '0)) begin
            busy_set[reserve_sel] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reserve wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    assign rs1_busy = busy[rs1_sel];
    assign rs2_busy = busy[rs2_sel];

endmodule

// File: tb/tb_apu_wb_queue.sv
// tb_apu_wb_queue: directed and random stimulus against a queue-based reference model.
// Honours APU_WB_DROP_X0_EN in the same way as the design.
module tb_apu_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_sel;
    logic [31:0] in_data;
    logic        apu_wr_req;
    logic        apu_ack;
    logic [4:0]  apu_wr_sel;
    logic [31:0] apu_wr_data;
    logic        reserve_valid;
    logic [4:0]  reserve_sel;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [2:0]  count;

    apu_wb_queue dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_data      (in_data),
        .apu_wr_req   (apu_wr_req),
        .apu_ack      (apu_ack),
        .apu_wr_sel   (apu_wr_sel),
        .apu_wr_data  (apu_wr_data),
        .reserve_valid(reserve_valid),
        .reserve_sel  (reserve_sel),
        .rs1_sel      (rs1_sel),
        .rs2_sel      (rs2_sel),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mbusy = '0;
    bit          m_req = 0;
    bit          m_wait = 0;
    bit          chk_en = 0;
    int          total = 0;
    int          bad = 0;
    int          req_hi = 0;
    logic [4:0]  wlog[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Write port: a write is offered one cycle after the port is free and
    // an entry is present, held until acknowledged; acks only count after
    // the one-cycle request pulse.
    task automatic model_step();
        bit          popped;
        bit          nreq;
        bit          pushed;
        logic [31:0] nb;
        if (!rst) begin
            q.delete();
            mbusy  = '0;
            m_req  = 0;
            m_wait = 0;
            return;
        end
        popped = m_wait && apu_ack;
        nreq   = 0;
        if (m_req) begin
            m_wait = 1;
        end else if (popped) begin
            m_wait = 0;
            nreq   = (q.size() - 1) > 0;
        end else if (!m_wait) begin
            nreq = q.size() > 0;
        end
        pushed = in_valid && ((q.size() != DEPTH) || popped);
        nb = mbusy;
        if (popped) begin
            nb[q[0].sel] = 1'b0;
            void'(q.pop_front());
        end
        if (reserve_valid && reserve_sel != 0) nb[reserve_sel] = 1'b1;
`ifdef APU_WB_DROP_X0_EN
        if (pushed && in_sel != 0) q.push_back('{in_sel, in_data});
`else
        if (pushed) q.push_back('{in_sel, in_data});
`endif
        mbusy = nb;
        m_req = nreq;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("count", {29'd0, count}, q.size());
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() != DEPTH});
            chk("req", {31'd0, apu_wr_req}, {31'd0, m_req});
            chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, mbusy[rs1_sel]});
            chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, mbusy[rs2_sel]});
            if ((m_req || m_wait) && q.size() > 0) begin
                chk("wr_sel", {27'd0, apu_wr_sel}, {27'd0, q[0].sel});
                chk("wr_data", apu_wr_data, q[0].data);
            end
            if (apu_wr_req) begin
                wlog.push_back(apu_wr_sel);
                req_hi++;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(logic [4:0] s, logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_req(string nm);
        int n = 0;
        while (!apu_wr_req && n < 20) begin
            step();
            n++;
        end
        chk(nm, {31'd0, apu_wr_req}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        apu_ack = 1'b1;
        while ((count != 0 || apu_wr_req) && n < 60) begin
            step();
            n++;
        end
        apu_ack = 1'b0;
        step();
        step();
        chk("drain", {29'd0, count}, 32'd0);
    endtask

    task automatic chk_log(string nm, logic [4:0] e0, logic [4:0] e1,
                           logic [4:0] e2, logic [4:0] e3);
        logic [4:0] e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_len"}, wlog.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) chk(nm, {27'd0, wlog[i]}, {27'd0, e[i]});
        end
    endtask

    initial begin
        int r0;
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_sel        = '0;
        in_data       = '0;
        apu_ack       = 1'b0;
        reserve_valid = 1'b0;
        reserve_sel   = '0;
        rs1_sel       = '0;
        rs2_sel       = '0;
        #2 rst = 1'b0;
        chk_en = 1;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_req", {31'd0, apu_wr_req}, 32'd0);
        chk("rst_sel", {27'd0, apu_wr_sel}, 32'd0);
        chk("rst_data", apu_wr_data, 32'd0);

        // single write, ack one cycle after req
        r0 = req_hi;
        push1(5'd5, 32'hDEADBEEF);
        wait_req("t1_req");
        chk("t1_sel", {27'd0, apu_wr_sel}, 32'd5);
        chk("t1_data", apu_wr_data, 32'hDEADBEEF);
        step();
        apu_ack = 1'b1;
        step();
        apu_ack = 1'b0;
        chk("t1_count", {29'd0, count}, 32'd0);
        step();
        step();
        chk("t1_req_once", req_hi - r0, 32'd1);
        chk("t1_idle", {31'd0, apu_wr_req}, 32'd0);

        // fill with ack withheld, then release in order
        wlog.delete();
        for (int i = 1; i <= 4; i++) push1(5'(i), 32'h100 + i);
        chk("t2_count", {29'd0, count}, 32'd4);
        chk("t2_ready", {31'd0, in_ready}, 32'd0);
        push1(5'd9, 32'h999);
        chk("t2_5th", {29'd0, count}, 32'd4);
        drain();
        chk_log("t2_order", 5'd1, 5'd2, 5'd3, 5'd4);

        // scoreboard set/clear
        rs1_sel = 5'd7;
        rs2_sel = 5'd0;
        reserve_valid = 1'b1;
        reserve_sel   = 5'd7;
        chk("t3_nobypass", {31'd0, rs1_busy}, 32'd0);
        step();
        reserve_valid = 1'b0;
        chk("t3_busy", {31'd0, rs1_busy}, 32'd1);
        push1(5'd7, 32'h77);
        wait_req("t3_req");
        step();
        apu_ack = 1'b1;
        chk("t3_pending", {31'd0, rs1_busy}, 32'd1);
        step();
        apu_ack = 1'b0;
        chk("t3_clear", {31'd0, rs1_busy}, 32'd0);
        chk("t3_x0", {31'd0, rs2_busy}, 32'd0);

        // reserve while retiring the same register
        rs1_sel = 5'd3;
        reserve_valid = 1'b1;
        reserve_sel   = 5'd3;
        step();
        reserve_valid = 1'b0;
        push1(5'd3, 32'h33);
        wait_req("t4_req");
        step();
        apu_ack = 1'b1;
        reserve_valid = 1'b1;
        step();
        apu_ack = 1'b0;
        reserve_valid = 1'b0;
        chk("t4_setwins", {31'd0, rs1_busy}, 32'd1);

        // full queue: push and retire together
        for (int i = 10; i <= 13; i++) push1(5'(i), 32'h1000 + i);
        step();
        chk("t5_full", {29'd0, count}, 32'd4);
        wlog.delete();
        apu_ack  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 5'd14;
        in_data  = 32'h1014;
        chk("t5_ready0", {31'd0, in_ready}, 32'd0);
        step();
        apu_ack  = 1'b0;
        in_valid = 1'b0;
        chk("t5_count", {29'd0, count}, 32'd4);
        drain();
        chk_log("t5_order", 5'd11, 5'd12, 5'd13, 5'd14);

        // reset in WAIT with 3 queued
        rs1_sel = 5'd8;
        reserve_valid = 1'b1;
        reserve_sel   = 5'd8;
        step();
        reserve_valid = 1'b0;
        for (int i = 20; i < 23; i++) push1(5'(i), 32'h2000 + i);
        step();
        rst = 1'b0;
        step();
        chk("t6_req", {31'd0, apu_wr_req}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_busy", {31'd0, rs1_busy}, 32'd0);
        chk("t6_sel", {27'd0, apu_wr_sel}, 32'd0);
        rst = 1'b1;
        r0 = req_hi;
        apu_ack = 1'b1;
        step();
        step();
        step();
        apu_ack = 1'b0;
        chk("t6_lateack", req_hi - r0, 32'd0);
        chk("t6_empty", {29'd0, count}, 32'd0);

`ifdef APU_WB_DROP_X0_EN
        r0 = req_hi;
        push1(5'd0, 32'hABCD);
        step();
        step();
        chk("t7_drop_count", {29'd0, count}, 32'd0);
        chk("t7_drop_req", req_hi - r0, 32'd0);
`endif

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid      = ($urandom % 2) == 0;
            in_sel        = 5'($urandom);
            in_data       = $urandom;
            apu_ack       = ($urandom % 3) != 0;
            reserve_valid = ($urandom % 4) == 0;
            reserve_sel   = 5'($urandom);
            rs1_sel       = 5'($urandom);
            rs2_sel       = 5'($urandom);
            if ($urandom_range(0, 699) == 0) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
            end
            step();
        end
        in_valid      = 1'b0;
        reserve_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
